alu_issue_stage: RTL and testbench

- Decode/issue stage directly upstream of the RV64I ALU.
- Accepts 32-bit instructions over a valid/ready handshake and decodes RV64I OP (R-type) and OP-IMM (I-type) arithmetic/logic instructions.
- Reads operands from an internal register file, tracks outstanding destinations with a scoreboard, and presents registered a, b, funct3, funct7 and rd to the ALU.
- Accepts ALU results back on a write-back port.

---
 rtl/rv64_pkg.sv | 64 ++++++
 rtl/alu_issue_stage_regfile.sv | 38 +++
 rtl/alu_issue_stage.sv | 142 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// Shared RV64I decode constants and the OP/OP-IMM field decoder used by the ALU issue stage.
package rv64_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic        legal;
    logic        is_op;
    logic        is_shift;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;
  } decode_t;

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    d        = '0;
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.imm12  = instr[31:20];
    case (instr[6:0])
      OPC_OP: begin
        d.is_op  = 1'b1;
        d.funct7 = instr[31:25];
        d.legal  = (instr[31:25] == F7_BASE) ||
                   ((instr[31:25] == F7_ALT) &&
                    ((instr[14:12] == F3_ADD) || (instr[14:12] == F3_SR)));
      end
      OPC_OP_IMM: begin
        d.legal = 1'b1;
        // Only shifts carry a modifier; forcing it to zero elsewhere keeps ADDI from looking like SUB.
        if ((instr[14:12] == F3_SLL) || (instr[14:12] == F3_SR)) begin
          d.is_shift = 1'b1;
          d.funct7   = {instr[31:26], 1'b0};
        end else begin
          d.funct7 = F7_BASE;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port, x0 reads as zero.
module regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/alu_issue_stage.sv
// RV64I OP/OP-IMM decode and issue stage with scoreboard hazard stalls.
// Define ALU_ISSUE_WB_BYPASS_EN to forward same-cycle write-back data straight into the operands.
module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  import rv64_pkg::*;

  decode_t         dec;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] src1, src2, imm_ext;
  logic            busy1, busy2, hazard, transfer;

  logic [31:0]     busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [2:0]      out_funct3_q, out_funct3_d;
  logic [6:0]      out_funct7_q, out_funct7_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_illegal_q, out_illegal_d;

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (dec.rs1),
    .rd1 (rf_rd1),
    .ra2 (dec.rs2),
    .rd2 (rf_rd2),
    .we  (wb_valid),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  always_comb begin
    dec     = decode(in_instr);
    imm_ext = dec.is_shift ? {{(XLEN-6){1'b0}}, dec.imm12[5:0]}
                           : {{(XLEN-12){dec.imm12[11]}}, dec.imm12};
    busy1   = dec.legal && busy_q[dec.rs1];
    busy2   = dec.legal && dec.is_op && busy_q[dec.rs2];
`ifdef ALU_ISSUE_WB_BYPASS_EN
    src1   = (wb_valid && (wb_rd == dec.rs1) && (dec.rs1 != 5'd0)) ? wb_data : rf_rd1;
    src2   = (wb_valid && (wb_rd == dec.rs2) && (dec.rs2 != 5'd0)) ? wb_data : rf_rd2;
    hazard = (busy1 && !(wb_valid && (wb_rd == dec.rs1))) ||
             (busy2 && !(wb_valid && (wb_rd == dec.rs2)));
`else
    src1   = rf_rd1;
    src2   = rf_rd2;
    hazard = busy1 || busy2;
`endif
    in_ready = (!out_valid_q || out_ready) && !hazard;
    transfer = in_valid && in_ready;
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_funct3_d  = out_funct3_q;
    out_funct7_d  = out_funct7_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    if (transfer) begin
      out_valid_d   = 1'b1;
      out_illegal_d = !dec.legal;
      if (dec.legal) begin
        out_a_d      = src1;
        out_b_d      = dec.is_op ? src2 : imm_ext;
        out_funct3_d = dec.funct3;
        out_funct7_d = dec.funct7;
        out_rd_d     = dec.rd;
      end else begin
        out_a_d      = '0;
        out_b_d      = '0;
        out_funct3_d = 3'b000;
        out_funct7_d = 7'b0000000;
        out_rd_d     = 5'd0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear first so that a same-cycle issue to the same register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_rd != 5'd0)) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (transfer && dec.legal && (dec.rd != 5'd0)) begin
      busy_d[dec.rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_funct3_q  <= 3'b000;
      out_funct7_q  <= 7'b0000000;
      out_rd_q      <= 5'd0;
      out_illegal_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_funct3_q  <= out_funct3_d;
      out_funct7_q  <= out_funct7_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_funct3  = out_funct3_q;
  assign out_funct7  = out_funct7_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage; follows ALU_ISSUE_WB_BYPASS_EN for the bypass expectations.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int tests;
  int errors;

  alu_issue_stage #(.XLEN(64), .NREG(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 64'h0;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    tests++; if (out_a !== 64'h0 || out_b !== 64'h0) begin errors++; $display("[TB] FAIL reset_ab: got a=%h b=%h expected 0", out_a, out_b); end
    tests++; if (out_funct3 !== 3'd0 || out_funct7 !== 7'd0 || out_rd !== 5'd0 || out_illegal !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_fields: got f3=%b f7=%b rd=%0d ill=%b expected 0", out_funct3, out_funct7, out_rd, out_illegal); end
    tests++; if (dut.busy_q !== 32'h0) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 0", dut.busy_q); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_addi();
    in_instr = enc_i(12'hFFB, 5'd0, 3'b000, 5'd1);
    in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL addi_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid: got %b expected 1", out_valid); end
    tests++; if (out_a !== 64'h0) begin errors++; $display("[TB] FAIL addi_a: got %h expected 0", out_a); end
    tests++; if (out_b !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("[TB] FAIL addi_b: got %h expected fffffffffffffffb", out_b); end
    tests++; if (out_funct3 !== 3'b000 || out_funct7 !== 7'b0000000) begin errors++; $display("[TB] FAIL addi_funct: got f3=%b f7=%b expected 000/0000000", out_funct3, out_funct7); end
    tests++; if (out_rd !== 5'd1 || out_illegal !== 1'b0) begin errors++; $display("[TB] FAIL addi_rd: got rd=%0d ill=%b expected 1/0", out_rd, out_illegal); end
    tests++; if (dut.busy_q[1] !== 1'b1) begin errors++; $display("[TB] FAIL addi_busy: got %b expected 1", dut.busy_q[1]); end
  endtask

  task automatic test_back_to_back();
    in_instr = enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd3);
    in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall0: got %b expected 0", in_ready); end
    tick();
    tests++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall1: got %b expected 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid); end
    tick();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 64'd7;
    #1;
`ifdef ALU_ISSUE_WB_BYPASS_EN
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wb_ready: got %b expected 1", in_ready); end
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
`else
    tests++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wb_ready: got %b expected 0", in_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_bubble: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_late_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
`endif
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd3) begin errors++; $display("[TB] FAIL b2b_issue: got valid=%b rd=%0d expected 1/3", out_valid, out_rd); end
    tests++; if (out_a !== 64'd7 || out_b !== 64'd7) begin errors++; $display("[TB] FAIL b2b_operands: got a=%h b=%h expected 7/7", out_a, out_b); end
    tests++; if (dut.busy_q[1] !== 1'b0 || dut.busy_q[3] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got b1=%b b3=%b expected 0/1", dut.busy_q[1], dut.busy_q[3]); end
  endtask

  task automatic test_srai();
    in_instr = {6'b010000, 6'd63, 5'd1, 3'b101, 5'd2, 7'b0010011};
    in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL srai_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_b !== 64'd63 || out_a !== 64'd7) begin errors++; $display("[TB] FAIL srai_operands: got a=%h b=%h expected 7/3f", out_a, out_b); end
    tests++; if (out_funct7 !== 7'b0100000 || out_funct3 !== 3'b101) begin errors++; $display("[TB] FAIL srai_funct: got f7=%b f3=%b expected 0100000/101", out_funct7, out_funct3); end
    tests++; if (out_rd !== 5'd2) begin errors++; $display("[TB] FAIL srai_rd: got %0d expected 2", out_rd); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_instr = enc_i(12'd100, 5'd0, 3'b000, 5'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_a !== 64'd7 || out_b !== 64'd63 || out_funct7 !== 7'b0100000)
        begin errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b rd=%0d a=%h b=%h f7=%b expected 1/2/7/3f/0100000", i, out_valid, out_rd, out_a, out_b, out_funct7); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_rd !== 5'd4 || out_b !== 64'd100 || out_a !== 64'd0 || out_funct7 !== 7'd0)
      begin errors++; $display("[TB] FAIL bp_queued: got rd=%0d a=%h b=%h f7=%b expected 4/0/64/0", out_rd, out_a, out_b, out_funct7); end
  endtask

  task automatic test_illegal();
    in_instr = 32'h0000_0073;
    in_valid = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin errors++; $display("[TB] FAIL sys_illegal: got valid=%b ill=%b expected 1/1", out_valid, out_illegal); end
    tests++; if (out_rd !== 5'd0 || out_funct3 !== 3'd0 || out_funct7 !== 7'd0 || out_a !== 64'd0 || out_b !== 64'd0)
      begin errors++; $display("[TB] FAIL sys_fields: got rd=%0d f3=%b f7=%b a=%h b=%h expected all 0", out_rd, out_funct3, out_funct7, out_a, out_b); end
    in_instr = enc_r(7'b0100000, 5'd5, 5'd6, 3'b100, 5'd7);
    tick();
    in_valid = 1'b0;
    tests++; if (out_illegal !== 1'b1 || out_rd !== 5'd0 || out_funct3 !== 3'd0 || out_funct7 !== 7'd0)
      begin errors++; $display("[TB] FAIL sub_illegal: got ill=%b rd=%0d f3=%b f7=%b expected 1/0/0/0", out_illegal, out_rd, out_funct3, out_funct7); end
    tests++; if (dut.busy_q !== 32'h0000_001C) begin errors++; $display("[TB] FAIL illegal_busy: got %h expected 0000001c", dut.busy_q); end
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hDEAD;
    tick();
    wb_rd = 5'd3; wb_data = 64'h1234;
    tick();
    wb_valid = 1'b0;
    in_instr = enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd8);
    in_valid = 1'b1;
    tick();
    tests++; if (out_a !== 64'd0 || out_b !== 64'd0 || out_rd !== 5'd8) begin errors++; $display("[TB] FAIL x0_read: got a=%h b=%h rd=%0d expected 0/0/8", out_a, out_b, out_rd); end
    in_instr = enc_r(7'b0000000, 5'd0, 5'd3, 3'b110, 5'd9);
    tick();
    in_valid = 1'b0;
    tests++; if (out_a !== 64'h1234 || out_funct3 !== 3'b110 || out_rd !== 5'd9) begin errors++; $display("[TB] FAIL wb_read: got a=%h f3=%b rd=%0d expected 1234/110/9", out_a, out_funct3, out_rd); end
    tests++; if (dut.busy_q !== 32'h0000_0314) begin errors++; $display("[TB] FAIL x0_busy: got %h expected 00000314", dut.busy_q); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_instr = enc_r(7'b0000000, 5'd9, 5'd9, 3'b000, 5'd10);
    in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall_ready: got %b expected 0", in_ready); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_rd !== 5'd0) begin errors++; $display("[TB] FAIL rst_stall_out: got valid=%b rd=%0d expected 0/0", out_valid, out_rd); end
    tests++; if (dut.busy_q !== 32'h0) begin errors++; $display("[TB] FAIL rst_stall_busy: got %h expected 0", dut.busy_q); end
    out_ready = 1'b1;
    in_instr = enc_r(7'b0000000, 5'd0, 5'd3, 3'b000, 5'd10);
    #1;
    tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_after_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_a !== 64'd0 || out_rd !== 5'd10 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_rf_cleared: got a=%h rd=%0d valid=%b expected 0/10/1", out_a, out_rd, out_valid); end
  endtask

  initial begin
    tests = 0;
    errors = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_srai();
    test_backpressure();
    test_illegal();
    test_x0();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
